// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : DEPTH x N register file with one synchronous write port, two
//             combinational read ports, optional same-cycle write-to-read
//             bypass and a hardwired-zero entry 0. Asynchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int N      = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [N-1:0]      data_in,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [N-1:0]      data_out_a,
  output logic [N-1:0]      data_out_b
);

  localparam bit c_bypass = (BYPASS != 0);

  // A write only takes effect when not in reset and not aimed at entry 0.
  logic              w_wr_en;
  logic [N-1:0]      w_entry [DEPTH];
  logic [N-1:0]      w_rd_a;
  logic [N-1:0]      w_rd_b;

  assign w_wr_en = load && !reset && (write_addr != '0);

  // Entry 0 has no storage; it is a constant zero in the read array.
  assign w_entry[0] = '0;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
    logic [N-1:0] r_word;

    // Storage word: cleared asynchronously, loaded when addressed.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_word <= '0;
      end else if (w_wr_en && (write_addr == ADDR_W'(gi))) begin
        r_word <= data_in;
      end
    end

    assign w_entry[gi] = r_word;
  end

  // Read muxes with optional forwarding of the in-flight write; reset wins.
  always_comb begin
    w_rd_a = w_entry[read_addr_a];
    w_rd_b = w_entry[read_addr_b];
    if (c_bypass && w_wr_en && (read_addr_a == write_addr)) begin
      w_rd_a = data_in;
    end
    if (c_bypass && w_wr_en && (read_addr_b == write_addr)) begin
      w_rd_b = data_in;
    end
    if (reset) begin
      w_rd_a = '0;
      w_rd_b = '0;
    end
  end

  assign data_out_a = w_rd_a;
  assign data_out_b = w_rd_b;

endmodule
`default_nettype wire
